// File: rtl/serial_pkg.sv
// Shared serial-link definitions used by the piso serializer and sipo deframer.
// Holds the FSM state encoding and the on-wire bit order.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam bit MSB_FIRST = 1'b1;

endpackage

// File: rtl/word_hold.sv
// One-deep valid/ready holding register for completed words.
// Raises overrun_out for one cycle when a load arrives while full and stalled.
module word_hold #(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         reset_in,
    input  logic         load_in,
    input  logic [W-1:0] load_data_in,
    input  logic         ready_in,
    output logic [W-1:0] data_out,
    output logic         valid_out,
    output logic         overrun_out
);

    logic can_load;
    logic take;

    always_comb begin
        take        = valid_out && ready_in;
        can_load    = !valid_out || ready_in;
        overrun_out = load_in && !can_load;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else if (load_in && can_load) begin
            data_out  <= load_data_in;
            valid_out <= 1'b1;
        end else if (take) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo.sv
// Serial-in/parallel-out deframer: assembles framed words from a sampled
// bit stream and hands them to a one-deep valid/ready holding register.
module sipo
    import serial_pkg::*;
#(
    parameter int SIZE       = 8,
    parameter bit CONTINUOUS = 1'b1
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            data_in,
    input  logic            bit_valid_in,
    input  logic            frame_start_in,
    output logic [SIZE-1:0] data_out,
    output logic            valid_out,
    input  logic            ready_in,
    output logic            overrun_out,
    output logic            frame_err_out,
    input  logic            clear_in
);

    localparam int CW = $clog2(SIZE);
    localparam logic [CW-1:0] LAST_CNT  = CW'(SIZE - 1);
    localparam logic [CW-1:0] FIRST_CNT = CW'(SIZE - 2);

    state_t          state;
    logic [SIZE-1:0] shreg;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] first_word;
    logic [SIZE-1:0] next_word;
    logic            word_done;
    logic            at_boundary;
    logic            frame_err_evt;
    logic            overrun_evt;

    always_comb begin
        if (MSB_FIRST) begin
            first_word = {{(SIZE-1){1'b0}}, data_in};
            next_word  = {shreg[SIZE-2:0], data_in};
        end else begin
            first_word = {data_in, {(SIZE-1){1'b0}}};
            next_word  = {data_in, shreg[SIZE-1:1]};
        end
        at_boundary   = CONTINUOUS && (cnt == LAST_CNT);
        word_done     = bit_valid_in && !frame_start_in &&
                        (state == SHIFT) && (cnt == '0);
        frame_err_evt = bit_valid_in && frame_start_in &&
                        (state == SHIFT) && !at_boundary;
    end

    // A frame start always restarts the word; only its legality differs.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else if (bit_valid_in) begin
            if (frame_start_in) begin
                shreg <= first_word;
                cnt   <= FIRST_CNT;
                state <= SHIFT;
            end else if (state == SHIFT) begin
                shreg <= next_word;
                if (cnt == '0) begin
                    cnt   <= CONTINUOUS ? LAST_CNT : '0;
                    state <= CONTINUOUS ? SHIFT : IDLE;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    word_hold #(
        .W (SIZE)
    ) u_hold (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .load_in      (word_done),
        .load_data_in (next_word),
        .ready_in     (ready_in),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .overrun_out  (overrun_evt)
    );

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            overrun_out   <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            if (overrun_evt)
                overrun_out <= 1'b1;
            else if (clear_in)
                overrun_out <= 1'b0;
            if (frame_err_evt)
                frame_err_out <= 1'b1;
            else if (clear_in)
                frame_err_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sipo.sv
// Bench for sipo: one-shot and free-running instances share stimulus
// and are compared every cycle against a word-level model.
module tb_sipo;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic       data_in;
    logic       bit_valid_in;
    logic       frame_start_in;
    logic       ready_in;
    logic       clear_in;
    logic [7:0] d0, d1;
    logic       v0, v1, o0, o1, f0, f1;

    int total  = 0;
    int passed = 0;

    always #5 clk_in = ~clk_in;

    sipo #(.SIZE(8), .CONTINUOUS(1'b0)) u_oneshot (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .data_in        (data_in),
        .bit_valid_in   (bit_valid_in),
        .frame_start_in (frame_start_in),
        .data_out       (d0),
        .valid_out      (v0),
        .ready_in       (ready_in),
        .overrun_out    (o0),
        .frame_err_out  (f0),
        .clear_in       (clear_in)
    );

    sipo #(.SIZE(8), .CONTINUOUS(1'b1)) u_free (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .data_in        (data_in),
        .bit_valid_in   (bit_valid_in),
        .frame_start_in (frame_start_in),
        .data_out       (d1),
        .valid_out      (v1),
        .ready_in       (ready_in),
        .overrun_out    (o1),
        .frame_err_out  (f1),
        .clear_in       (clear_in)
    );

    // Model: index 0 is one-shot, index 1 is free-running.
    int         nb  [2];
    bit         inw [2];
    int         acc [2];
    logic [7:0] hd  [2];
    bit         hv  [2];
    bit         ov  [2];
    bit         fe  [2];

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            nb[m]  = 0;
            inw[m] = 1'b0;
            acc[m] = 0;
            hd[m]  = 8'h00;
            hv[m]  = 1'b0;
            ov[m]  = 1'b0;
            fe[m]  = 1'b0;
        end
    endfunction

    function automatic void model_step();
        for (int m = 0; m < 2; m++) begin
            bit         done = 1'b0;
            bit         drop = 1'b0;
            bit         err  = 1'b0;
            logic [7:0] w    = 8'h00;
            bit         take = hv[m] && ready_in;
            if (bit_valid_in) begin
                if (frame_start_in) begin
                    err    = inw[m] && (nb[m] > 0);
                    inw[m] = 1'b1;
                    nb[m]  = 1;
                    acc[m] = int'(data_in);
                end else if (inw[m]) begin
                    acc[m] = acc[m] * 2 + int'(data_in);
                    nb[m]  = nb[m] + 1;
                    if (nb[m] == 8) begin
                        done   = 1'b1;
                        w      = 8'(acc[m]);
                        nb[m]  = 0;
                        acc[m] = 0;
                        inw[m] = (m == 1);
                    end
                end
            end
            if (done) begin
                if (!hv[m] || ready_in) begin
                    hd[m] = w;
                    hv[m] = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end else if (take) begin
                hv[m] = 1'b0;
            end
            if (drop)
                ov[m] = 1'b1;
            else if (clear_in)
                ov[m] = 1'b0;
            if (err)
                fe[m] = 1'b1;
            else if (clear_in)
                fe[m] = 1'b0;
        end
    endfunction

    task automatic check(input string name, input int m,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s dut%0d t=%0t got %0h want %0h",
                     name, m, $time, act, exp);
    endtask

    task automatic compare_model();
        check("data_out", 0, 32'(d0), 32'(hd[0]));
        check("valid_out", 0, 32'(v0), 32'(hv[0]));
        check("overrun_out", 0, 32'(o0), 32'(ov[0]));
        check("frame_err_out", 0, 32'(f0), 32'(fe[0]));
        check("data_out", 1, 32'(d1), 32'(hd[1]));
        check("valid_out", 1, 32'(v1), 32'(hv[1]));
        check("overrun_out", 1, 32'(o1), 32'(ov[1]));
        check("frame_err_out", 1, 32'(f1), 32'(fe[1]));
    endtask

    task automatic cyc(input logic b, input logic bv, input logic fs,
                       input logic r, input logic c);
        data_in        = b;
        bit_valid_in   = bv;
        frame_start_in = fs;
        ready_in       = r;
        clear_in       = c;
        model_step();
        @(posedge clk_in);
        #1;
        compare_model();
    endtask

    task automatic send_word(input logic [7:0] w, input logic framed,
                             input logic r, input logic r_last);
        for (int i = 7; i >= 0; i--)
            cyc(w[i], 1'b1, framed && (i == 7),
                (i == 0) ? r_last : r, 1'b0);
    endtask

    initial begin
        reset_in       = 1'b1;
        data_in        = 1'b0;
        bit_valid_in   = 1'b0;
        frame_start_in = 1'b0;
        ready_in       = 1'b0;
        clear_in       = 1'b0;
        model_reset();
        #12;
        check("rst_data", 0, 32'(d0), 32'h0);
        check("rst_valid", 0, 32'(v0), 32'h0);
        check("rst_ovr", 1, 32'(o1), 32'h0);
        check("rst_ferr", 1, 32'(f1), 32'h0);
        reset_in = 1'b0;

        // Single framed word, consumer ready.
        send_word(8'hA5, 1'b1, 1'b1, 1'b1);
        check("t1_valid", 0, 32'(v0), 32'h1);
        check("t1_data", 0, 32'(d0), 32'hA5);
        check("t1_data", 1, 32'(d1), 32'hA5);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t1_drop", 0, 32'(v0), 32'h0);

        // Free-running stream of one framed word then unframed repeats.
        send_word(8'h3C, 1'b1, 1'b1, 1'b1);
        check("t2_w0", 1, 32'(d1), 32'h3C);
        for (int k = 0; k < 2; k++) begin
            send_word(8'h3C, 1'b0, 1'b1, 1'b1);
            check("t2_valid", 1, 32'(v1), 32'h1);
            check("t2_data", 1, 32'(d1), 32'h3C);
        end
        check("t2_ferr", 1, 32'(f1), 32'h0);
        check("t2_oneshot_idle", 0, 32'(v0), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Stalled consumer: second word is dropped.
        send_word(8'h11, 1'b1, 1'b0, 1'b0);
        send_word(8'h22, 1'b1, 1'b0, 1'b0);
        check("t3_hold", 0, 32'(d0), 32'h11);
        check("t3_ovr", 0, 32'(o0), 32'h1);
        check("t3_ovr", 1, 32'(o1), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_taken", 0, 32'(v0), 32'h0);
        check("t3_keep", 0, 32'(d0), 32'h11);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t3_clr", 0, 32'(o0), 32'h0);

        // Frame start three bits into a word.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        send_word(8'h5A, 1'b1, 1'b1, 1'b1);
        check("t4_ferr", 0, 32'(f0), 32'h1);
        check("t4_ferr", 1, 32'(f1), 32'h1);
        check("t4_data", 0, 32'(d0), 32'h5A);
        check("t4_valid", 1, 32'(v1), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a word.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        reset_in = 1'b1;
        model_reset();
        #1;
        check("t5_data", 0, 32'(d0), 32'h0);
        check("t5_valid", 1, 32'(v1), 32'h0);
        check("t5_ferr", 0, 32'(f0), 32'h0);
        #2;
        reset_in = 1'b0;
        send_word(8'hC3, 1'b1, 1'b1, 1'b1);
        check("t5_word", 0, 32'(d0), 32'hC3);
        check("t5_word", 1, 32'(d1), 32'hC3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Completion on the same cycle the previous word is taken.
        send_word(8'h11, 1'b1, 1'b0, 1'b0);
        send_word(8'h22, 1'b1, 1'b0, 1'b1);
        check("t6_data", 0, 32'(d0), 32'h22);
        check("t6_valid", 0, 32'(v0), 32'h1);
        check("t6_ovr", 0, 32'(o0), 32'h0);
        check("t6_ovr", 1, 32'(o1), 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++)
            cyc(1'($urandom), ($urandom_range(3) != 0),
                ($urandom_range(15) == 0), ($urandom_range(2) != 0),
                ($urandom_range(31) == 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
